// File: rtl/pixel_stream_packer.sv
// Packs one RGB pixel per handshake into a 32-bit AXI4-Stream video beat, with
// raster-derived tuser/tlast and a two-entry skid buffer for registered backpressure.
module pixel_stream_packer #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480,
    parameter int XW     = 10,
    parameter int YW     = 9
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic [7:0]    in_r,
    input  logic [7:0]    in_g,
    input  logic [7:0]    in_b,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   m_axis_tdata,
    output logic [3:0]    m_axis_tkeep,
    output logic          m_axis_tuser,
    output logic          m_axis_tlast,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [XW-1:0] x_pos,
    output logic [YW-1:0] y_pos,
    output logic          frame_done
);

    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t      state;
    state_t      state_next;
    logic [23:0] out_pix;
    logic [23:0] skid_pix;
    logic        accept;
    logic        xfer;
    logic        load_out;
    logic        load_skid;
    logic        move_skid;
    logic        last_x;
    logic        last_y;

    assign accept        = in_valid & in_ready;
    assign xfer          = m_axis_tvalid & m_axis_tready;
    assign m_axis_tvalid = (state != EMPTY);
    assign m_axis_tdata  = {8'h00, out_pix};
    assign m_axis_tkeep  = 4'hF;
    assign last_x        = (x_pos == X_LAST);
    assign last_y        = (y_pos == Y_LAST);
    assign m_axis_tuser  = m_axis_tvalid && (x_pos == '0) && (y_pos == '0);
    assign m_axis_tlast  = m_axis_tvalid && last_x;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_out   = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && xfer) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = TWO;
                end else if (xfer) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (xfer) begin
                    move_skid  = 1'b1;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // in_ready comes from a flop so downstream tready never reaches it combinationally
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (state_next != TWO);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_pix  <= '0;
            skid_pix <= '0;
        end else begin
            if (load_out) begin
                out_pix <= {in_r, in_g, in_b};
            end else if (move_skid) begin
                out_pix <= skid_pix;
            end
            if (load_skid) begin
                skid_pix <= {in_r, in_g, in_b};
            end
        end
    end

    // Counters track the beat in the output register, so they step on every transfer
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x_pos      <= '0;
            y_pos      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= xfer && last_x && last_y;
            if (xfer) begin
                if (last_x) begin
                    x_pos <= '0;
                    y_pos <= last_y ? '0 : y_pos + 1'b1;
                end else begin
                    x_pos <= x_pos + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed bench for pixel_stream_packer on a 4x2 raster: packing, flags, skid
// backpressure, tready toggling, mid-frame reset and frame wrap.
module tb_pixel_stream_packer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  in_r = '0;
    logic [7:0]  in_g = '0;
    logic [7:0]  in_b = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [1:0]  x_pos;
    logic [0:0]  y_pos;
    logic        frame_done;

    pixel_stream_packer #(.X_SIZE(4), .Y_SIZE(2), .XW(2), .YW(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_valid(in_valid), .in_ready(in_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .x_pos(x_pos), .y_pos(y_pos), .frame_done(frame_done)
    );

    always #5 aclk = ~aclk;

    int          total = 0;
    int          bad = 0;
    logic [23:0] exp_q[$];
    int          next_px = 0;
    int          to_send = 0;
    int          beat_k = 0;
    int          fd_count = 0;
    int          tuser_cnt = 0;
    int          tlast_cnt = 0;
    int          rdy_low = 0;
    bit          tog = 1'b0;

    function automatic logic [23:0] pix(input int n);
        logic [7:0] a;
        a = n[7:0];
        return {a, a + 8'd1, a + 8'd2};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        in_valid = (to_send > 0);
        {in_r, in_g, in_b} = pix(next_px);
    endtask

    task automatic check_beat();
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            chk("stale_beat", {32'h0, m_axis_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            return;
        end
        e = exp_q.pop_front();
        chk("tdata", m_axis_tdata, {8'h00, e});
        chk("tkeep", m_axis_tkeep, 4'hF);
        chk("tuser", m_axis_tuser, (beat_k % 8) == 0);
        chk("tlast", m_axis_tlast, (beat_k % 4) == 3);
        chk("x_pos", x_pos, beat_k % 4);
        chk("y_pos", y_pos, (beat_k / 4) % 2);
        if (m_axis_tuser) tuser_cnt++;
        if (m_axis_tlast) tlast_cnt++;
        beat_k++;
    endtask

    // One clock: sample at negedge, advance, update the upstream source after the edge
    task automatic tick();
        bit acc;
        @(negedge aclk);
        acc = in_valid && in_ready;
        if (frame_done) fd_count++;
        if (!in_ready && to_send > 0) rdy_low++;
        if (m_axis_tvalid && m_axis_tready) check_beat();
        @(posedge aclk);
        #1;
        if (acc) begin
            exp_q.push_back(pix(next_px));
            next_px++;
            to_send--;
        end
        if (tog) m_axis_tready = ~m_axis_tready;
        drive();
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 300 && (to_send > 0 || exp_q.size() > 0); c++) tick();
        chk({tag, "_timeout"}, (to_send > 0 || exp_q.size() > 0), 0);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        in_valid = 1'b0;
        to_send = 0;
        #2;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_flags", {m_axis_tuser, m_axis_tlast, frame_done}, 0);
        chk("rst_pos", {x_pos, y_pos}, 0);
        exp_q.delete();
        beat_k = 0; fd_count = 0; tuser_cnt = 0; tlast_cnt = 0; rdy_low = 0; tog = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        chk("rel_in_ready_low", in_ready, 0);
        @(posedge aclk);
        #1;
        chk("rel_in_ready_high", in_ready, 1);
        chk("rel_tvalid", m_axis_tvalid, 0);
    endtask

    initial begin
        // 1: reset release
        do_reset();

        // 2: one frame at full rate
        m_axis_tready = 1'b1;
        next_px = 0; to_send = 8; drive();
        tick();
        chk("t2_first_tdata", m_axis_tdata, 32'h00000102);
        chk("t2_first_tuser", m_axis_tuser, 1);
        drain("t2");
        chk("t2_beats", beat_k, 8);
        chk("t2_tlast_cnt", tlast_cnt, 2);
        chk("t2_frame_done", fd_count, 1);
        chk("t2_no_stall", rdy_low, 0);

        // 3: stall fills the skid buffer
        do_reset();
        m_axis_tready = 1'b0;
        next_px = 8'h40; to_send = 3; drive();
        repeat (4) tick();
        chk("t3_in_ready", in_ready, 0);
        chk("t3_accepted", exp_q.size(), 2);
        chk("t3_tvalid", m_axis_tvalid, 1);
        chk("t3_hold_tdata", m_axis_tdata, 32'h00404142);
        m_axis_tready = 1'b1;
        tick();
        chk("t3_ready_back", in_ready, 1);
        chk("t3_second_tdata", m_axis_tdata, 32'h00414243);
        drain("t3");
        chk("t3_beats", beat_k, 3);

        // 4: tready toggling over two frames
        do_reset();
        m_axis_tready = 1'b1; tog = 1'b1;
        next_px = 8'h80; to_send = 16; drive();
        drain("t4");
        chk("t4_beats", beat_k, 16);
        chk("t4_tuser_cnt", tuser_cnt, 2);
        chk("t4_tlast_cnt", tlast_cnt, 4);
        chk("t4_frame_done", fd_count, 2);

        // 5: reset mid-frame then resend
        do_reset();
        m_axis_tready = 1'b1;
        next_px = 8'hA0; to_send = 6; drive();
        for (int c = 0; c < 50 && beat_k < 3; c++) tick();
        chk("t5_pre_beats", beat_k, 3);
        do_reset();
        m_axis_tready = 1'b1;
        next_px = 8'hC0; to_send = 4; drive();
        tick();
        chk("t5_first_tdata", m_axis_tdata, 32'h00C0C1C2);
        chk("t5_first_tuser", m_axis_tuser, 1);
        chk("t5_first_pos", {x_pos, y_pos}, 0);
        drain("t5");
        chk("t5_beats", beat_k, 4);

        // 6: back-to-back frames
        do_reset();
        m_axis_tready = 1'b1;
        next_px = 0; to_send = 16; drive();
        drain("t6");
        chk("t6_beats", beat_k, 16);
        chk("t6_tuser_cnt", tuser_cnt, 2);
        chk("t6_frame_done", fd_count, 2);
        chk("t6_pos_wrap", {x_pos, y_pos}, 0);
        chk("t6_idle", m_axis_tvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
- Sits directly downstream of the pixel buffer. Accepts one 8-bit RGB pixel per handshake and packs it into a 32-bit AXI4-Stream video beat.
- Generates tuser (start of frame) and tlast (end of line) from internal x/y raster counters.
- Provides full-throughput registered backpressure through a two-entry skid buffer, so the downstream ready never combinationally reaches the upstream ready.

Parameters:
- X_SIZE, 640, pixels per line (≥2)
- Y_SIZE, 480, lines per frame (≥2)
- XW, 10, x counter width (must hold X_SIZE-1)
- YW, 9, y counter width (must hold Y_SIZE-1)

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- in_r  in  8  pixel red
- in_g  in  8  pixel green
- in_b  in  8  pixel blue
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  block can accept a pixel; registered
- m_axis_tdata  out  32  packed pixel
- m_axis_tkeep  out  4  byte enables, constant 4'hF
- m_axis_tuser  out  1  first pixel of frame
- m_axis_tlast  out  1  last pixel of line
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- x_pos  out  XW  column of the beat currently on the output
- y_pos  out  YW  line of the beat currently on the output
- frame_done  out  1  one-cycle pulse after the last beat of a frame transfers

Behaviour:
- Reset is aresetn, asynchronous, active-low; clock is aclk. All state is in the aclk domain.
- Reset values:
  - in_ready=0, m_axis_tvalid=0, tdata=0, tuser=0, tlast=0.
  - x_pos=0, y_pos=0, frame_done=0, state=EMPTY.
- in_ready rises on the first aclk edge after reset release.
- Packing:
  - tdata[31:24]=8'h00, [23:16]=r, [15:8]=g, [7:0]=b.
  - tkeep=4'hF at all times.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = tvalid & tready.
  - tdata, tuser and tlast are held stable while tvalid=1 and tready=0.
- State machine (occupancy of output register plus skid register):
  - EMPTY: tvalid=0, in_ready=1. On accept: load output register, go to ONE.
  - ONE: tvalid=1, in_ready=1.
    - Accept and transfer together: load output register, stay in ONE.
    - Accept only: load skid register, go to TWO.
    - Transfer only: go to EMPTY.
  - TWO: tvalid=1, in_ready=0.
    - On transfer: move skid register to output register, go to ONE.
- Latency: a pixel accepted at edge N is on tdata after edge N if the output register is free or being drained.
- Sustained throughput: 1 pixel/cycle when tready is held at 1.
- Raster counters:
  - x_pos and y_pos describe the beat currently in the output register.
  - They advance only on output transfer: x increments; at x=X_SIZE-1, x wraps to 0 and y increments.
  - At x=X_SIZE-1 and y=Y_SIZE-1, both wrap to 0.
- Flags:
  - tuser = (x_pos==0 && y_pos==0) while tvalid.
  - tlast = (x_pos==X_SIZE-1) while tvalid.
  - Both flags are 0 whenever tvalid=0.
- frame_done: single-cycle pulse on the edge following the transfer of the beat with x=X_SIZE-1, y=Y_SIZE-1.
- Boundary conditions:
  - in_valid while in_ready=0: no effect. The pixel is not lost, because upstream holds it.
  - tready toggling every cycle: no pixel is dropped or duplicated, and order is preserved.
  - Reset mid-frame: both registers are flushed, counters return to 0, and the next accepted pixel is tagged tuser=1.
- Pixels are never reordered or modified; the block has no arithmetic beyond counter increments.

Test Plan:
1. Reset release with in_valid=0 → tvalid=0, and in_ready goes 1 one cycle after release.
2. X_SIZE=4, Y_SIZE=2, tready=1, 8 pixels with r=i, g=i+1, b=i+2 → 8 beats at 1/cycle:
   - beat0 tdata=32'h00000102, tuser=1.
   - tlast=1 on beats 3 and 7.
   - frame_done pulses once after beat7.
3. Hold tready=0 with in_valid=1 → two pixels accepted, then in_ready=0. tdata stays at the first pixel. On tready=1, beats emerge in order and in_ready returns to 1 one cycle later.
4. tready toggling 1010… over 16 pixels (X_SIZE=4, Y_SIZE=2) → all 16 delivered in order. tuser is set on beats 0 and 8; tlast on every 4th beat.
5. Assert aresetn=0 after 3 beats of a frame, then resend → first post-reset beat has tuser=1, x_pos=0, y_pos=0, and no stale beat appears.
6. Frame wrap: 2 back-to-back frames (X_SIZE=4, Y_SIZE=2) → tuser on beats 0 and 8, frame_done pulses after beats 7 and 15, and y_pos returns to 0.
